// File: rtl/weight_pkg.sv
// Shared sizes, types and LFSR constants for the weight initialisation path.
// Helper functions give the LFSR step and the weight scaling from a raw LFSR state.
package weight_pkg;

  localparam int NUM_IN      = 30;
  localparam int NUM_HID     = 5;
  localparam int NUM_OUT     = 3;
  localparam int NUM_WEIGHTS = NUM_IN * NUM_HID + NUM_HID * NUM_OUT;
  localparam int WEIGHT_W    = 10;
  localparam int ADDR_W      = 8;
  localparam int MAG_SHIFT   = 2;

  typedef logic signed [WEIGHT_W-1:0] weight_t;
  typedef logic        [ADDR_W-1:0]   addr_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Low WEIGHT_W bits taken as a signed value, then shrunk to keep initial weights small.
  function automatic weight_t scale_weight(input logic [15:0] s);
    weight_t raw;
    raw = s[WEIGHT_W-1:0];
    return raw >>> MAG_SHIFT;
  endfunction

endpackage

// File: rtl/weight_init_writer_if.sv
// Control handshake plus RAM write-side signals of the weight initialiser.
// slave is the writer itself; master is the controller/RAM side that observes it.
interface weight_init_writer_if;
  import weight_pkg::*;

  logic        start;
  logic [15:0] seed;
  logic        pause;
  weight_t     D;
  addr_t       Address;
  logic        WE;
  logic        busy;
  logic        done;

  modport master (
    output start, seed, pause,
    input  D, Address, WE, busy, done
  );

  modport slave (
    input  start, seed, pause,
    output D, Address, WE, busy, done
  );

endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous active-low reset to the default state.
// load has priority over step; with neither asserted the state holds.
module lfsr16
  import weight_pkg::*;
(
  input  logic        Clock,
  input  logic        Rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] q
);

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      q <= LFSR_DEFAULT;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/weight_init_writer.sv
// Fills the weight RAM with LFSR-derived signed weights, one address per unpaused cycle,
// then pulses done. All outputs are registered; pause freezes the write sequence.
module weight_init_writer
  import weight_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Rst,
  weight_init_writer_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]  state;
  addr_t       cnt;
  logic [15:0] lfsr_q;
  logic [15:0] load_val;
  logic        lfsr_load;
  logic        lfsr_step;

  // An all-zero seed would lock the LFSR, so it is swapped for the default state.
  assign load_val  = (bus.seed == 16'h0000) ? LFSR_DEFAULT : bus.seed;
  assign lfsr_load = (state == S_IDLE) && bus.start;
  assign lfsr_step = (state == S_WRITE) && !bus.pause;

  lfsr16 u_lfsr (
    .Clock    (Clock),
    .Rst      (Rst),
    .load     (lfsr_load),
    .load_val (load_val),
    .step     (lfsr_step),
    .q        (lfsr_q)
  );

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bus.D       <= '0;
      bus.Address <= '0;
      bus.WE      <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.WE   <= 1'b0;
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.busy <= 1'b1;
            cnt      <= '0;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (bus.pause) begin
            bus.WE <= 1'b0;
          end else begin
            bus.WE      <= 1'b1;
            bus.Address <= cnt;
            bus.D       <= scale_weight(lfsr_q);
            cnt         <= cnt + 1'b1;
            if (cnt == addr_t'(NUM_WEIGHTS - 1)) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          bus.WE   <= 1'b0;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/weight_init_writer.md
Name: weight_init_writer

Overview:
- Sequencer that fills the weight RAM with pseudo-random signed weights before training starts.
- Drives the RAM's write side (D, Address, WE) and steps every weight address once.
- Uses a seeded 16-bit Galois LFSR to generate the weights.
- Sits between the top-level control FSM (start/done handshake) and the weight RAM; the RAM's read side is untouched.

Parameters:
- NUM_WEIGHTS, 165, number of weights written: 150 input->hidden plus 15 hidden->output.
- WEIGHT_W, 10, signed weight width.
- ADDR_W, 8, address width.
- MAG_SHIFT, 2, arithmetic right shift applied to the raw weight to limit its magnitude.

Ports:
- Clock  in  1  rising-edge clock.
- Rst  in  1  reset: synchronous, active-low.
- start  in  1  single-cycle request to begin initialisation.
- seed  in  16  LFSR seed, sampled when start is accepted.
- pause  in  1  stall request; while high, no write is issued and all state is held.
- D  out  WEIGHT_W (signed)  weight data to the RAM.
- Address  out  ADDR_W  RAM address.
- WE  out  1  write enable; '1' means write.
- busy  out  1  high from start acceptance until the last write has been issued.
- done  out  1  one-cycle pulse after the final write.

Behaviour:
- Reset: all outputs are registered. When Rst=0 at a rising edge, all of the following hold from the next cycle:
  - D=0, Address=0, WE=0, busy=0, done=0.
  - state=IDLE, lfsr=16'hACE1.
  - Reset mid-run aborts immediately; no further writes are issued.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - If start=1, load the LFSR with seed; a seed of 0 is replaced by 16'hACE1.
  - Then set busy=1, clear the address counter and go to WRITE.
  - pause is ignored in IDLE.
- WRITE, per cycle with pause=0:
  - WE=1, Address=cnt, D=sext(lfsr[WEIGHT_W-1:0]) >>> MAG_SHIFT.
  - Then advance the LFSR and increment cnt.
  - The write for address 0 uses the seed state itself.
- LFSR step: lfsr = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000).
- WRITE with pause=1:
  - WE=0 in that cycle.
  - Address and D hold their previous values; LFSR and cnt hold.
- WRITE exit: after the cycle that writes address NUM_WEIGHTS-1, go to DONE.
- DONE: lasts exactly one cycle with done=1, WE=0, busy=0; then return to IDLE.
- Latency:
  - start is sampled at edge N.
  - Address 0 is written in the cycle after edge N+1.
  - With no pause, there are exactly NUM_WEIGHTS consecutive WE=1 cycles, then a 1-cycle done pulse.
  - Total: NUM_WEIGHTS+1 cycles after acceptance.
- start while busy or in DONE: ignored, with no restart.
- start and pause high together in IDLE: start is accepted.
- D and Address change only together, on the clock edge, and are stable for the whole WE=1 cycle.
- Address never exceeds NUM_WEIGHTS-1; cnt is wide enough that it cannot wrap.

Decomposition:
- Shared package weight_pkg holds:
  - NUM_WEIGHTS, WEIGHT_W, ADDR_W, NUM_IN=30, NUM_HID=5, NUM_OUT=3;
  - typedef weight_t (signed WEIGHT_W) and addr_t;
  - the LFSR constants LFSR_TAPS=16'hB400 and LFSR_DEFAULT=16'hACE1.
- One sub-module, lfsr16.
  - Inputs: Clock, Rst, load, load_val, step.
  - Output: q.
- The FSM and counter stay in weight_init_writer.

Test Plan:
- Seed 16'h0001, MAG_SHIFT=2, pause=0: the first four writes are
  - Address 0, D=0 (raw 1);
  - Address 1, D=0 (raw 0, lfsr 16'hB400);
  - Address 2, D=-128 (raw -512, lfsr 16'h5A00);
  - Address 3, D=64 (raw 256, lfsr 16'h2D00).
- Full run, seed 16'h1234:
  - exactly 165 WE=1 cycles, addresses 0..164 in order;
  - done=1 for one cycle at acceptance+166;
  - busy=0 afterwards;
  - every D is within [-128,127]; the scoreboard checks each D against a reference LFSR model.
- Seed 0:
  - the sequence is identical to the one produced by seed 16'hACE1;
  - the LFSR never locks at zero across 165 writes.
- pause held high for 3 cycles after Address 10:
  - WE=0 for those 3 cycles;
  - Address 10 and D are held;
  - Address 11 carries the same value as in an unpaused run;
  - done is delayed by exactly 3 cycles.
- start pulsed again at Address 50: ignored; the sequence continues to 164 unchanged with a single done pulse.
- Rst=0 asserted at Address 80:
  - the next cycle has WE=0, busy=0, Address=0, D=0;
  - with start re-issued and seed 16'h0001, the run restarts from Address 0 with the first scenario's values.
